mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port of the ARC datapath between two requesters: the instruction-fetch path (loads ir) and the data path (ld/st microinstructions).
- Arbitration is round-robin. Memory is treated as fixed-latency with a programmable number of wait states.
- The block returns a one-cycle acknowledge with captured read data to the winning requester.
- The control section holds its microinstruction until the acknowledge arrives.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_STATES, 1, extra memory cycles per access (legal range 0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch request; held high until i_ack.
- i_addr  input  AW  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse when the fetch completes.
- i_rdata  output  DW  fetched word; valid when i_ack=1 and held until the next fetch completes.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle pulse when the data access completes.
- d_rdata  output  DW  load data; valid when d_ack=1 and held until the next load completes.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; valid in the last access cycle.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=DATA, wait counter=0.
  - All outputs 0, including i_rdata and d_rdata.
  - A reset asserted mid-access drops mem_en and mem_we immediately. No ack is issued and the access is lost.
- State machine IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - Requests are sampled on the clock edge.
  - Only one request high: grant it.
  - Both high: grant the requester opposite to last_grant. Because of the reset value, fetch wins the first tie.
  - On grant, latch addr, we (forced 0 for fetch) and wdata into internal registers, set last_grant, load counter=WAIT_STATES, and go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_en=1; mem_addr, mem_we and mem_wdata driven from the latched registers.
  - Counter decrements each cycle.
  - In the cycle with counter==0: if the access is a read, capture mem_rdata into the granted requester's rdata register. Then go to ACK.
  - ACCESS therefore lasts exactly WAIT_STATES+1 cycles.
- ACK:
  - mem_en=0, mem_we=0.
  - Pulse the granted requester's ack for one cycle, then go to IDLE.
  - ACK is not a grant state, so a still-high req in the ack cycle is not re-served early. Requesters drop req the cycle after ack.
- Latency: req high at edge t (state IDLE) gives mem_en high for cycles t+1 .. t+1+WAIT_STATES, and ack at cycle t+2+WAIT_STATES. Minimum latency is 2 cycles (WAIT_STATES=0).
- Throughput: back-to-back requests from one requester cost WAIT_STATES+3 cycles each (IDLE/sample, ACCESS, ACK).
- Stores:
  - d_rdata is unchanged on a store.
  - mem_wdata is valid only while mem_en=1 and mem_we=1; it is 0 otherwise.
- Idle bus: mem_addr and mem_wdata are 0 while mem_en=0.
- Requester protocol:
  - A requester that drops req during ACCESS is not aborted; the access completes and ack still pulses.
  - Changes to addr, we or wdata after the grant are ignored.
- Simultaneous events: a new request arriving during ACCESS or ACK waits and is arbitrated at the next IDLE sample. Round-robin guarantees no requester waits more than one foreign access.
- Wait counter is 4 bits wide; WAIT_STATES outside 0..15 is illegal and flagged by a simulation-time check.

Test Plan:
- Reset then single fetch, WAIT_STATES=1, i_req at t, i_addr=0x00000800, mem_rdata=0x8210A005 in the last access cycle:
  - mem_en high at t+1 and t+2 with mem_addr=0x800.
  - i_ack pulses at t+3 with i_rdata=0x8210A005.
  - busy is low at t+4.
- Store, WAIT_STATES=0, d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF:
  - One cycle with mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF.
  - d_ack two cycles after the request.
  - d_rdata keeps its previous value.
- Contention: i_req and d_req both held high continuously after reset:
  - Grants alternate fetch, data, fetch, data.
  - Each ack is spaced WAIT_STATES+3 cycles apart.
  - Ack ordering is i, d, i, d.
- Mid-access reset: assert rst=0 during the second ACCESS cycle with WAIT_STATES=3:
  - mem_en falls without waiting for a clock edge, and no ack is issued.
  - After release, a new i_req completes normally and wins any tie, since last_grant=DATA.
- Requester drops req and changes addr during ACCESS:
  - mem_addr keeps the latched value.
  - The ack still pulses and a load's rdata is captured.
- WAIT_STATES=15 single load: mem_en is high for exactly 16 cycles; ack arrives 17 cycles after the grant edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory port of the ARC datapath between the
// instruction-fetch path and the data path (ld/st). The two requesters take
// turns in round-robin order. Memory is fixed-latency, with WAIT_STATES extra
// cycles per access. Each access runs IDLE -> ACCESS -> ACK -> IDLE.
//
// Parameters
//   AW           address width
//   DW           data width
//   WAIT_STATES  extra memory cycles per access (0..15)
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   i_req/i_addr       fetch request and address (held until i_ack)
//   i_ack/i_rdata      one-cycle fetch completion pulse, fetched word (held)
//   d_req/d_we/d_addr/d_wdata
//                      data request, store flag, address, store data
//   d_ack/d_rdata      one-cycle data completion pulse, load data (held)
//   mem_en/mem_we/mem_addr/mem_wdata
//                      memory strobe, write enable, address, write data
//                      (all zero whenever no access is in progress)
//   mem_rdata          memory read data, valid in the last access cycle
//   busy               high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   // The wait counter is 4 bits wide, so only 0..15 wait states fit.
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range
      $error("mem_port_arbiter: WAIT_STATES=%0d is outside 0..15", WAIT_STATES);
   end

   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   state_t     state;
   grant_t     last_grant;   // also identifies the owner of the access in flight
   logic [3:0] wait_cnt;
   logic       grant_fetch;

   // Round-robin pick. A lone request always wins; on a tie the requester
   // that was not served last wins.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      grant_fetch = 1'b0;
      if (i_req && d_req) begin
         grant_fetch = (last_grant == GNT_DATA);
      end else begin
         grant_fetch = i_req;
      end
   end

   // The mem_* output registers double as the grant latches. They are loaded
   // at grant, hold through ACCESS, and are cleared on the way to ACK. This
   // keeps the idle bus at zero and makes later requester changes invisible.
   // Because reset is asynchronous, a reset in the middle of an access drops
   // mem_en/mem_we at once and the access is simply lost.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GNT_DATA;
         wait_cnt   <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         // Acks are single-cycle pulses.
         i_ack <= 1'b0;
         d_ack <= 1'b0;

         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  state    <= ACCESS;
                  wait_cnt <= WS_LOAD;
                  mem_en   <= 1'b1;
                  if (grant_fetch) begin
                     last_grant <= GNT_FETCH;
                     mem_addr   <= i_addr;
                     mem_we     <= 1'b0;
                     mem_wdata  <= '0;
                  end else begin
                     last_grant <= GNT_DATA;
                     mem_addr   <= d_addr;
                     mem_we     <= d_we;
                     // Write data is only visible on the bus during a store.
                     mem_wdata  <= d_we ? d_wdata : '0;
                  end
               end
            end

            ACCESS: begin
               if (wait_cnt == 4'd0) begin
                  // Last access cycle: read data is valid now.
                  if (!mem_we) begin
                     if (last_grant == GNT_FETCH) begin
                        i_rdata <= mem_rdata;
                     end else begin
                        d_rdata <= mem_rdata;
                     end
                  end
                  if (last_grant == GNT_FETCH) begin
                     i_ack <= 1'b1;
                  end else begin
                     d_ack <= 1'b1;
                  end
                  mem_en    <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
                  state     <= ACK;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            // The ack cycle never grants. Requesters drop req after seeing
            // their ack, so the next IDLE sample sees their updated request.
            ACK: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
